// File: rtl/eth_rx_frame_fifo_if.sv
// AXI-stream bundle used on both sides of the receive frame buffer.
// The master drives data/valid/last/user; the slave drives ready.
interface eth_rx_frame_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer: whole frames are written, then committed or rewound,
// so the downstream consumer only ever sees complete good frames.
module eth_rx_frame_fifo #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter bit          DROP_BAD_FRAME = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    eth_rx_frame_fifo_if.slave  s_axis,
    eth_rx_frame_fifo_if.master m_axis,
    output logic                status_good_frame_o,
    output logic                status_bad_frame_o,
    output logic                status_overflow_o
);
    localparam logic [ADDR_WIDTH:0] PtrFull = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {StWrite, StDrop} state_e;

    logic [DATA_WIDTH:0] mem [2**ADDR_WIDTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_cur_q, wr_ptr_cur_d;
    logic [ADDR_WIDTH:0]   wr_ptr_commit_q, wr_ptr_commit_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  mem_we, full, empty, rd_adv, rd_load;

    // The MAC has no backpressure path, so the input is always ready.
    assign s_axis.tready = 1'b1;
    assign m_axis.tuser  = 1'b0;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    assign status_good_frame_o = good_q;
    assign status_bad_frame_o  = bad_q;
    assign status_overflow_o   = ovf_q;

    assign full  = (wr_ptr_cur_q - rd_ptr_q) == PtrFull;
    assign empty = (rd_ptr_q == wr_ptr_commit_q);

    always_comb begin
        state_d         = state_q;
        wr_ptr_cur_d    = wr_ptr_cur_q;
        wr_ptr_commit_d = wr_ptr_commit_q;
        mem_we          = 1'b0;
        good_d          = 1'b0;
        bad_d           = 1'b0;
        ovf_d           = 1'b0;
        if (s_axis.tvalid) begin
            unique case (state_q)
                StWrite: begin
                    if (full) begin
                        wr_ptr_cur_d = wr_ptr_commit_q;
                        if (s_axis.tlast) ovf_d = 1'b1;
                        else              state_d = StDrop;
                    end else begin
                        mem_we       = 1'b1;
                        wr_ptr_cur_d = wr_ptr_cur_q + 1'b1;
                        if (s_axis.tlast) begin
                            if (s_axis.tuser && DROP_BAD_FRAME) begin
                                wr_ptr_cur_d = wr_ptr_commit_q;
                                bad_d        = 1'b1;
                            end else begin
                                wr_ptr_commit_d = wr_ptr_cur_q + 1'b1;
                                good_d          = 1'b1;
                                bad_d           = s_axis.tuser;
                            end
                        end
                    end
                end
                StDrop: begin
                    if (s_axis.tlast) begin
                        ovf_d   = 1'b1;
                        state_d = StWrite;
                    end
                end
                default: state_d = StWrite;
            endcase
        end
    end

    // Output register refills whenever it is empty or its beat is being consumed.
    always_comb begin
        rd_adv   = !tvalid_q || m_axis.tready;
        rd_load  = !empty && rd_adv;
        tvalid_d = rd_adv ? !empty : tvalid_q;
        rd_ptr_d = rd_load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        if (rd_load) begin
            {tlast_d, tdata_d} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StWrite;
            wr_ptr_cur_q    <= '0;
            wr_ptr_commit_q <= '0;
            rd_ptr_q        <= '0;
            good_q          <= 1'b0;
            bad_q           <= 1'b0;
            ovf_q           <= 1'b0;
            tvalid_q        <= 1'b0;
            tlast_q         <= 1'b0;
            tdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_cur_q    <= wr_ptr_cur_d;
            wr_ptr_commit_q <= wr_ptr_commit_d;
            rd_ptr_q        <= rd_ptr_d;
            good_q          <= good_d;
            bad_q           <= bad_d;
            ovf_q           <= ovf_d;
            tvalid_q        <= tvalid_d;
            tlast_q         <= tlast_d;
            tdata_q         <= tdata_d;
        end
    end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Directed bench for the receive frame buffer: a default instance (2048 beats, drop bad frames)
// and a small instance (64 beats, forward bad frames) share one stimulus driver.
module tb_eth_rx_frame_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_user = 1'b0;
    logic       rdy0 = 1'b0;
    logic       rdy1 = 1'b0;
    logic       rnd_rdy = 1'b0;
    logic       rnd_bit = 1'b0;

    logic st_good0, st_bad0, st_ovf0, st_good1, st_bad1, st_ovf1;

    eth_rx_frame_fifo_if #(.DATA_WIDTH(8)) s0 ();
    eth_rx_frame_fifo_if #(.DATA_WIDTH(8)) m0 ();
    eth_rx_frame_fifo_if #(.DATA_WIDTH(8)) s1 ();
    eth_rx_frame_fifo_if #(.DATA_WIDTH(8)) m1 ();

    assign s0.tdata  = in_data;
    assign s0.tvalid = in_valid && !in_sel;
    assign s0.tlast  = in_last;
    assign s0.tuser  = in_user;
    assign s1.tdata  = in_data;
    assign s1.tvalid = in_valid && in_sel;
    assign s1.tlast  = in_last;
    assign s1.tuser  = in_user;
    assign m0.tready = rnd_rdy ? rnd_bit : rdy0;
    assign m1.tready = rdy1;

    eth_rx_frame_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(11), .DROP_BAD_FRAME(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0),
        .status_good_frame_o(st_good0), .status_bad_frame_o(st_bad0),
        .status_overflow_o(st_ovf0)
    );

    eth_rx_frame_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(6), .DROP_BAD_FRAME(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1),
        .status_good_frame_o(st_good1), .status_bad_frame_o(st_bad1),
        .status_overflow_o(st_ovf1)
    );

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    logic [8:0] q0[$], q1[$], exp_q[$];
    int good0 = 0, bad0 = 0, ovf0 = 0, good1 = 0, bad1 = 0, ovf1 = 0;
    int rcv0 = 0, stab_err = 0;
    logic       prev_hold = 1'b0;
    logic [8:0] prev_beat = 9'h0;

    // Handshakes are sampled mid-cycle; they complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && !(m0.tvalid && {m0.tlast, m0.tdata} == prev_beat)) stab_err++;
            prev_hold = m0.tvalid && !m0.tready;
            prev_beat = {m0.tlast, m0.tdata};
            if (m0.tvalid && m0.tready) begin
                q0.push_back({m0.tlast, m0.tdata});
                rcv0++;
            end
            if (m1.tvalid && m1.tready) q1.push_back({m1.tlast, m1.tdata});
            good0 += int'(st_good0);
            bad0  += int'(st_bad0);
            ovf0  += int'(st_ovf0);
            good1 += int'(st_good1);
            bad1  += int'(st_bad1);
            ovf1  += int'(st_ovf1);
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit sel, input int len, input logic [7:0] start,
                              input bit bad, input bit rnd);
        for (int i = 0; i < len; i++) begin
            in_sel   = sel;
            in_valid = 1'b1;
            in_data  = rnd ? 8'($urandom) : start + 8'(i);
            in_last  = (i == len - 1);
            in_user  = bad && (i == len - 1);
            if (rnd && !bad) exp_q.push_back({in_last, in_data});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input bit sel, input int len,
                                input logic [7:0] start);
        int         err;
        int         n;
        logic [8:0] b;
        logic [8:0] e;
        logic [7:0] d;
        err = 0;
        n = sel ? q1.size() : q0.size();
        check({tag, "_len"}, 32'(n), 32'(len));
        for (int i = 0; i < len && i < n; i++) begin
            b = sel ? q1.pop_front() : q0.pop_front();
            d = start + 8'(i);
            e = {(i == len - 1), d};
            if (b !== e) err++;
        end
        check({tag, "_data"}, 32'(err), 32'd0);
        if (sel) q1.delete();
        else     q0.delete();
    endtask

    initial begin
        int g0, b0, o0, g1, b1, o1;
        int sent, base, ngood, nbad, waited, timeouts, mism, len;
        bit bad;

        idle(3);
        check("rst_tvalid0", 32'(m0.tvalid), 32'd0);
        check("rst_tlast0", 32'(m0.tlast), 32'd0);
        check("rst_tdata0", 32'(m0.tdata), 32'd0);
        check("rst_status0", 32'({st_good0, st_bad0, st_ovf0}), 32'd0);
        check("rst_tvalid1", 32'(m1.tvalid), 32'd0);
        rst = 1'b0;
        idle(2);

        // 64-byte good frame, consumer always ready.
        rdy0 = 1'b1;
        g0 = good0;
        send_frame(0, 64, 8'h00, 0, 0);
        check("t1_good_pulse", 32'(st_good0), 32'd1);
        check("t1_tvalid_at_commit", 32'(m0.tvalid), 32'd0);
        idle(1);
        check("t1_tvalid_next", 32'(m0.tvalid), 32'd1);
        check("t1_first_byte", 32'(m0.tdata), 32'h00);
        check("t1_good_pulse_end", 32'(st_good0), 32'd0);
        idle(70);
        expect_frame("t1", 0, 64, 8'h00);
        check("t1_good_cnt", 32'(good0 - g0), 32'd1);

        // Bad frame dropped, following good frame intact.
        g0 = good0; b0 = bad0;
        send_frame(0, 60, 8'h10, 1, 0);
        send_frame(0, 64, 8'h00, 0, 0);
        idle(70);
        expect_frame("t2", 0, 64, 8'h00);
        check("t2_bad_cnt", 32'(bad0 - b0), 32'd1);
        check("t2_good_cnt", 32'(good0 - g0), 32'd1);

        // Bad frame forwarded when dropping is disabled.
        rdy1 = 1'b1;
        g1 = good1; b1 = bad1;
        send_frame(1, 60, 8'h40, 1, 0);
        idle(66);
        expect_frame("t2b", 1, 60, 8'h40);
        check("t2b_bad_cnt", 32'(bad1 - b1), 32'd1);
        check("t2b_good_cnt", 32'(good1 - g1), 32'd1);

        // Two 40-byte frames into 64 beats with the consumer stalled.
        rdy1 = 1'b0;
        g1 = good1; o1 = ovf1;
        send_frame(1, 40, 8'h00, 0, 0);
        send_frame(1, 40, 8'h80, 0, 0);
        idle(3);
        check("t3_ovf_cnt", 32'(ovf1 - o1), 32'd1);
        check("t3_good_cnt", 32'(good1 - g1), 32'd1);
        check("t3_hold_valid", 32'(m1.tvalid), 32'd1);
        check("t3_hold_data", 32'(m1.tdata), 32'h00);
        rdy1 = 1'b1;
        idle(60);
        expect_frame("t3", 1, 40, 8'h00);
        check("t3_tvalid_end", 32'(m1.tvalid), 32'd0);

        // Oversize frame dropped, short frame after it survives.
        g1 = good1; o1 = ovf1;
        send_frame(1, 100, 8'h00, 0, 0);
        send_frame(1, 10, 8'h20, 0, 0);
        idle(20);
        check("t4_ovf_cnt", 32'(ovf1 - o1), 32'd1);
        check("t4_good_cnt", 32'(good1 - g1), 32'd1);
        expect_frame("t4", 1, 10, 8'h20);

        // Random frames with a randomly stalling consumer, scoreboarded.
        rnd_rdy = 1'b1;
        exp_q.delete();
        q0.delete();
        base = rcv0; sent = 0; ngood = 0; nbad = 0; timeouts = 0;
        g0 = good0; b0 = bad0; o0 = ovf0;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 300);
            bad = ($urandom_range(0, 9) == 0);
            waited = 0;
            while ((sent - (rcv0 - base)) + len > 2000 && waited < 5000) begin
                idle(1);
                waited++;
            end
            if (waited >= 5000) timeouts++;
            send_frame(0, len, 8'h00, bad, 1);
            if (bad) nbad++;
            else begin
                sent += len;
                ngood++;
            end
            idle($urandom_range(0, 3));
        end
        waited = 0;
        while ((rcv0 - base) < sent && waited < 20000) begin
            idle(1);
            waited++;
        end
        if (waited >= 20000) timeouts++;
        rnd_rdy = 1'b0;
        idle(2);
        check("rnd_timeout", 32'(timeouts), 32'd0);
        check("rnd_len", 32'(q0.size()), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < q0.size() && i < exp_q.size(); i++) begin
            if (q0[i] !== exp_q[i]) mism++;
        end
        check("rnd_data", 32'(mism), 32'd0);
        check("rnd_good_cnt", 32'(good0 - g0), 32'(ngood));
        check("rnd_bad_cnt", 32'(bad0 - b0), 32'(nbad));
        check("rnd_ovf_cnt", 32'(ovf0 - o0), 32'd0);
        check("rnd_stable", 32'(stab_err), 32'd0);
        q0.delete();
        exp_q.delete();

        // Asynchronous reset while a frame is waiting at the output.
        rdy0 = 1'b0;
        send_frame(0, 64, 8'h00, 0, 0);
        idle(3);
        check("t6_valid_before", 32'(m0.tvalid), 32'd1);
        g0 = good0; b0 = bad0; o0 = ovf0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid_async", 32'(m0.tvalid), 32'd0);
        check("t6_data_async", 32'(m0.tdata), 32'd0);
        idle(2);
        check("t6_status_in_rst", 32'({st_good0, st_bad0, st_ovf0}), 32'd0);
        rst = 1'b0;
        idle(3);
        check("t6_no_pulses", 32'((good0 - g0) + (bad0 - b0) + (ovf0 - o0)), 32'd0);
        check("t6_valid_after", 32'(m0.tvalid), 32'd0);
        q0.delete();
        rdy0 = 1'b1;
        send_frame(0, 64, 8'h40, 0, 0);
        idle(70);
        expect_frame("t6", 0, 64, 8'h40);
        check("t6_good_cnt", 32'(good0 - g0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
